// File: rtl/rgb2y_pipe.sv
// Three-stage RGB-to-luma pipeline with aligned strobes and a per-frame valid-pixel counter.
// The luma output and the sync/valid strobes feed the histogram stage directly.
module rgb2y_pipe #(
  parameter int unsigned COEF_R   = 77,
  parameter int unsigned COEF_G   = 150,
  parameter int unsigned COEF_B   = 29,
  parameter int unsigned CNT_BITS = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          r_i,
  input  logic [7:0]          g_i,
  input  logic [7:0]          b_i,
  input  logic                dv_i,
  input  logic                hs_i,
  input  logic                vs_i,
  output logic [7:0]          y_o,
  output logic                dv_o,
  output logic                hs_o,
  output logic                vs_o,
  output logic [CNT_BITS-1:0] pix_cnt_o,
  output logic                frame_done_o
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned COEF_W = 9;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned SUM_W  = 19;
  localparam int unsigned YF_W   = SUM_W - PIX_W;

  localparam logic [COEF_W-1:0]   CR       = COEF_W'(COEF_R);
  localparam logic [COEF_W-1:0]   CG       = COEF_W'(COEF_G);
  localparam logic [COEF_W-1:0]   CB       = COEF_W'(COEF_B);
  localparam logic [SUM_W-1:0]    ROUND    = SUM_W'(128);
  localparam logic [YF_W-1:0]     Y_MAX    = YF_W'(255);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  // stage 1: products and strobes
  logic              v1_q, v1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [PROD_W-1:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  // stage 2: rounded sum
  logic              v2_q, v2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [SUM_W-1:0]  s_q, s_d;
  // stage 3: outputs
  logic              dv_q, dv_d, hs_q, hs_d, vs_q, vs_d;
  logic [PIX_W-1:0]  y_q, y_d;
  // frame accounting
  logic                vs_prev_q, vs_prev_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] pix_cnt_q, pix_cnt_d;
  logic                frame_done_q, frame_done_d;

  logic [YF_W-1:0] y_full;
  logic            vs_rise;

  always_comb begin
    v1_d  = dv_i;
    hs1_d = hs_i;
    vs1_d = vs_i;
    pr_d  = pr_q;
    pg_d  = pg_q;
    pb_d  = pb_q;
    if (dv_i) begin
      pr_d = PROD_W'(CR) * PROD_W'(r_i);
      pg_d = PROD_W'(CG) * PROD_W'(g_i);
      pb_d = PROD_W'(CB) * PROD_W'(b_i);
    end
  end

  always_comb begin
    v2_d  = v1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    s_d   = s_q;
    if (v1_q) begin
      s_d = SUM_W'(pr_q) + SUM_W'(pg_q) + SUM_W'(pb_q) + ROUND;
    end
  end

  // Drop the 8 fractional bits, then clamp to the 8-bit luma range.
  always_comb begin
    y_full = s_q[SUM_W-1:PIX_W];
    dv_d   = v2_q;
    hs_d   = hs2_q;
    vs_d   = vs2_q;
    y_d    = y_q;
    if (v2_q) begin
      y_d = (y_full > Y_MAX) ? 8'hFF : y_full[PIX_W-1:0];
    end
  end

  // A pixel coinciding with the vs rise belongs to the frame that is starting.
  always_comb begin
    vs_rise      = vs_q & ~vs_prev_q;
    vs_prev_d    = vs_q;
    frame_done_d = vs_rise;
    pix_cnt_d    = pix_cnt_q;
    cnt_d        = cnt_q;
    if (vs_rise) begin
      pix_cnt_d = cnt_q;
      cnt_d     = dv_q ? CNT_ONE : '0;
    end else if (dv_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q         <= 1'b0;
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      pr_q         <= '0;
      pg_q         <= '0;
      pb_q         <= '0;
      v2_q         <= 1'b0;
      hs2_q        <= 1'b0;
      vs2_q        <= 1'b0;
      s_q          <= '0;
      dv_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      y_q          <= '0;
      vs_prev_q    <= 1'b0;
      cnt_q        <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      pr_q         <= pr_d;
      pg_q         <= pg_d;
      pb_q         <= pb_d;
      v2_q         <= v2_d;
      hs2_q        <= hs2_d;
      vs2_q        <= vs2_d;
      s_q          <= s_d;
      dv_q         <= dv_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      y_q          <= y_d;
      vs_prev_q    <= vs_prev_d;
      cnt_q        <= cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign y_o          = y_q;
  assign dv_o         = dv_q;
  assign hs_o         = hs_q;
  assign vs_o         = vs_q;
  assign pix_cnt_o    = pix_cnt_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_rgb2y_pipe.sv
// Scoreboard bench for rgb2y_pipe: three instances (default coefs, alternate coefs, 4-bit counter)
// checked against an arithmetic luma model and a frame-boundary pixel-count model.
module tb_rgb2y_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] r_i = '0, g_i = '0, b_i = '0;
  logic       dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;

  logic [7:0]  y_a, y_b, y_s;
  logic        dv_a, dv_b, dv_s, hs_a, hs_b, hs_s, vs_a, vs_b, vs_s;
  logic        fd_a, fd_b, fd_s;
  logic [23:0] pix_a, pix_b;
  logic [3:0]  pix_s;

  rgb2y_pipe u_a (
    .clk(clk), .rst(rst), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_o(y_a), .dv_o(dv_a), .hs_o(hs_a), .vs_o(vs_a),
    .pix_cnt_o(pix_a), .frame_done_o(fd_a)
  );

  rgb2y_pipe #(.COEF_R(100), .COEF_G(200), .COEF_B(50)) u_b (
    .clk(clk), .rst(rst), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_o(y_b), .dv_o(dv_b), .hs_o(hs_b), .vs_o(vs_b),
    .pix_cnt_o(pix_b), .frame_done_o(fd_b)
  );

  rgb2y_pipe #(.CNT_BITS(4)) u_s (
    .clk(clk), .rst(rst), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_o(y_s), .dv_o(dv_s), .hs_o(hs_s), .vs_o(vs_s),
    .pix_cnt_o(pix_s), .frame_done_o(fd_s)
  );

  typedef struct {int cyc; int ya; int yb;} pix_t;
  typedef struct {int cyc; int cnt;} frm_t;

  pix_t       pq[$];
  frm_t       fq[$];
  logic [2:0] hist[int];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_cnt = 0;
  bit model_prev_vs = 1'b0;
  int exp_pix = 0, exp_ps = 0;
  int last_ya = 0, last_yb = 0;
  int chk_from = 1 << 30;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int luma(int cr, int cg, int cb, int r, int g, int b);
    int y;
    y = (cr * r + cg * g + cb * b + 128) / 256;
    return (y > 255) ? 255 : y;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of input and advance the reference model.
  task automatic step(bit dv, int r, int g, int b, bit hs, bit vs);
    pix_t p;
    frm_t f;
    @(posedge clk);
    #1;
    dv_i = dv; r_i = 8'(r); g_i = 8'(g); b_i = 8'(b); hs_i = hs; vs_i = vs;
    hist[cyc] = {dv, hs, vs};
    if (vs && !model_prev_vs) begin
      f.cyc = cyc + 4;
      f.cnt = model_cnt;
      fq.push_back(f);
      model_cnt = 0;
    end
    model_prev_vs = vs;
    if (dv) begin
      model_cnt++;
      p.cyc = cyc + 3;
      p.ya  = luma(77, 150, 29, r, g, b);
      p.yb  = luma(100, 200, 50, r, g, b);
      pq.push_back(p);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(255)), 0, 0, 1'b0, 1'b0);
  endtask

  task automatic pixel(int r, int g, int b);
    step(1'b1, r, g, b, 1'b0, 1'b0);
  endtask

  task automatic reset_check(string tag);
    check({tag, "_y"},    int'(y_a),   0);
    check({tag, "_dv"},   int'(dv_a),  0);
    check({tag, "_hs"},   int'(hs_a),  0);
    check({tag, "_vs"},   int'(vs_a),  0);
    check({tag, "_pix"},  int'(pix_a), 0);
    check({tag, "_fd"},   int'(fd_a),  0);
    check({tag, "_pixs"}, int'(pix_s), 0);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2;
    rst = 1'b1;
    chk_from = cyc;
    hist[cyc] = 3'b000;
  endtask

  // Mid-cycle asynchronous reset; in-flight pixels and the running count are discarded.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    #1;
    reset_check("midrst");
    pq.delete();
    fq.delete();
    model_cnt = 0;
    model_prev_vs = 1'b0;
    exp_pix = 0; exp_ps = 0;
    last_ya = 0; last_yb = 0;
    repeat (2) @(posedge clk);
    release_rst();
  endtask

  // Monitor: pops expectations whenever the DUT is due to present a pixel or a frame report.
  always @(negedge clk) begin
    if (rst) begin
      bit   exp_dv, exp_fd;
      pix_t p;
      frm_t f;
      if (cyc - 3 >= chk_from && hist.exists(cyc - 3)) begin
        check("hs_a", int'(hs_a), int'(hist[cyc-3][1]));
        check("vs_a", int'(vs_a), int'(hist[cyc-3][0]));
        check("hs_b", int'(hs_b), int'(hist[cyc-3][1]));
        check("vs_b", int'(vs_b), int'(hist[cyc-3][0]));
        check("hs_s", int'(hs_s), int'(hist[cyc-3][1]));
        check("vs_s", int'(vs_s), int'(hist[cyc-3][0]));
      end
      while (pq.size() > 0 && pq[0].cyc < cyc) void'(pq.pop_front());
      exp_dv = (pq.size() > 0 && pq[0].cyc == cyc);
      check("dv_a", int'(dv_a), int'(exp_dv));
      check("dv_b", int'(dv_b), int'(exp_dv));
      check("dv_s", int'(dv_s), int'(exp_dv));
      if (exp_dv) begin
        p = pq.pop_front();
        last_ya = p.ya;
        last_yb = p.yb;
      end
      check("y_a", int'(y_a), last_ya);
      check("y_b", int'(y_b), last_yb);
      check("y_s", int'(y_s), last_ya);
      while (fq.size() > 0 && fq[0].cyc < cyc) void'(fq.pop_front());
      exp_fd = (fq.size() > 0 && fq[0].cyc == cyc);
      check("frame_done_a", int'(fd_a), int'(exp_fd));
      check("frame_done_b", int'(fd_b), int'(exp_fd));
      check("frame_done_s", int'(fd_s), int'(exp_fd));
      if (exp_fd) begin
        f = fq.pop_front();
        exp_pix = f.cnt;
        exp_ps  = (f.cnt > 15) ? 15 : f.cnt;
      end
      check("pix_cnt_a", int'(pix_a), exp_pix);
      check("pix_cnt_b", int'(pix_b), exp_pix);
      check("pix_cnt_s", int'(pix_s), exp_ps);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    reset_check("rst");
    release_rst();
    idle(3);

    // single pixels, both coefficient sets
    pixel(255, 0, 0);     idle(4);
    pixel(0, 255, 0);     idle(4);
    pixel(0, 0, 255);     idle(4);
    pixel(255, 255, 255); idle(4);
    pixel(128, 128, 128); idle(4);
    pixel(10, 10, 10);    idle(4);

    // sparse pixels with hs toggling; y_o must hold across the gaps
    for (int i = 0; i < 8; i++)
      step((i == 0 || i == 1 || i == 4), int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(255)), bit'(i % 2), 1'b0);
    idle(5);

    // 4 lines x 64 pixels, then a long vs pulse and an empty frame
    for (int l = 0; l < 4; l++) begin
      step(1'b0, 0, 0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 0, 0, 1'b1, 1'b0);
      for (int x = 0; x < 64; x++)
        pixel(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(10);
    for (int i = 0; i < 2; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(10);

    // pixel coinciding with the vs rise goes to the new frame
    for (int i = 0; i < 7; i++) pixel(int'($urandom_range(255)), 50, 60);
    step(1'b1, 200, 100, 50, 1'b0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) pixel(30, 60, 90);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(8);

    // random traffic with periodic vs
    for (int i = 0; i < 600; i++)
      step(($urandom_range(3) != 0), int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(255)), bit'($urandom_range(1)), ((i % 97) < 3));
    idle(8);

    // reset mid-frame, then a fresh frame of 5 pixels
    for (int i = 0; i < 9; i++) pixel(int'($urandom_range(255)), 1, 2);
    mid_reset();
    idle(20);
    for (int i = 0; i < 5; i++) pixel(int'($urandom_range(255)), 3, 4);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(12);

    check("pix_queue_drained", pq.size(), 0);
    check("frame_queue_drained", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
